mmio_timer: RTL and testbench
=============================

# mmio_timer

Memory-mapped machine timer peripheral on the core's `clk24` data bus. It provides a 64-bit prescaled `mtime` counter and `NUM_CHANNELS` independent 64-bit compare channels. Each channel has one-shot or periodic auto-reload mode, a sticky pending bit and an enable mask. It replaces the single fixed `mtime`/`mtimecmp` pair decoded in the top level; `irq` feeds the core's `mip_mtip` input.

## Interface
Parameters:
- `BASE_ADDRESS`, 32'h80000000: byte address of register 0; must be 256-byte aligned.
- `NUM_CHANNELS`, 4: compare channels, legal range 1..8.
- `PRESCALE_WIDTH`, 16: width of the prescaler divisor register, legal range 1..32.

Ports:
- `clk24` in 1: sole clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `address` in 32: byte address from the core, held for one cycle per access.
- `write_value` in 32: write data, already shifted into byte lanes.
- `write_sections` in 4: byte-lane write strobes; 0 means read-only access.
- `read_value` out 32: unshifted word at the decoded register, registered.
- `read_hit` out 1: registered; 1 when the previous cycle's `address` fell in the block's 256-byte window.
- `channel_irq` out NUM_CHANNELS: equals `status & enable`, registered.
- `irq` out 1: OR of `channel_irq`, registered.

## Operation
Register map, byte offsets from BASE_ADDRESS. Decode uses address[7:2].
- 0x00 MTIME_LO, 0x04 MTIME_HI: read/write.
- 0x08 PRESCALE: R/W, low PRESCALE_WIDTH bits; upper bits read as 0.
- 0x0C STATUS: per-channel pending bits; writing 1 clears a bit (W1C).
- 0x10 ENABLE: per-channel interrupt enable, R/W.
- 0x20+0x10·n: CMP_LO of channel n.
- 0x24+0x10·n: CMP_HI of channel n.
- 0x28+0x10·n: PERIOD of channel n, 32-bit.
- 0x2C+0x10·n: CTRL of channel n; bit0 PERIODIC.
- Unmapped offsets inside the window: reads return 0 with `read_hit`=1; writes are ignored.

Prescaler and mtime:
- `presc_cnt` counts up each cycle. When it equals PRESCALE, it returns to 0 and `mtime` increments by 1 (mod 2^64).
- PRESCALE=0 increments `mtime` every cycle.
- A write with any strobe to MTIME_LO or MTIME_HI updates only the strobed bytes. That cycle, `mtime` does not increment and `presc_cnt` is cleared.
- A write to PRESCALE clears `presc_cnt`.

Channels:
- Match condition: unsigned 64-bit `mtime >= cmp`, evaluated on registered values.
- On any match cycle, `status[n]` is set. If a W1C clear and a match occur in the same cycle, the set wins.
- One-shot (PERIODIC=0): `cmp` is unchanged, so `status` keeps re-asserting until software moves `cmp` or `mtime`.
- Periodic (PERIODIC=1, PERIOD≠0): on a match cycle, `cmp <= cmp + zero-extended PERIOD`, mod 2^64. At most one reload per cycle; catch-up takes successive cycles.
- Periodic with PERIOD=0 behaves as one-shot.
- A CPU write to a channel's CMP_LO/CMP_HI in a match cycle takes priority; the reload is suppressed that cycle.
- Reads return the pre-update register value of the access cycle.

Reset values: `mtime`=0, `presc_cnt`=0, PRESCALE=0, every `cmp`=all ones, PERIOD=0, CTRL=0, STATUS=0, ENABLE=0, `read_value`=0, `read_hit`=0, `channel_irq`=0, `irq`=0. Asserting `reset` mid-operation returns all state to these values immediately; no bus access completes.

## Timing
- Read latency is 1 cycle: `address` in cycle t gives `read_value`/`read_hit` valid in cycle t+1. Accesses can be issued back-to-back.
- Write latency is 1 cycle: register updated at the edge ending the access cycle.
- Match to `irq`:
  - First cycle with `mtime >= cmp` in registers: `status` is set at the end of that cycle.
  - `channel_irq`/`irq` rise one cycle later, 2 edges after `mtime` reaches `cmp`.
- W1C of STATUS with no match: `irq` falls 2 edges after the write cycle.
- ENABLE write: `irq` reflects the new mask 2 edges later.

## Configuration
- `MMIO_TIMER_PERIODIC_EN` defined: PERIOD and CTRL registers exist and the per-channel 64-bit reload adder is built.
- Undefined: PERIOD and CTRL offsets are unmapped (read 0, writes ignored). All channels are one-shot; no adders are built.

## Structure
- Package `mmio_timer_pkg`: register offset constants (OFF_MTIME_LO … OFF_CH_CTRL, CH_STRIDE=0x10, CH_BASE=0x20), CTRL bit index, and a byte-strobe merge function (old word, new word, strobes → merged word).
- Sub-module `mmio_timer_channel`, instantiated NUM_CHANNELS times. It holds `cmp`, PERIOD and CTRL, the match comparator and the reload adder. Its outputs are `match` and the read word for the selected sub-offset.
- Top `mmio_timer`: prescaler, `mtime`, STATUS/ENABLE, address decode, read mux, output registers.

## Test plan
- Reset, then read MTIME_LO twice one cycle apart with PRESCALE=0 → values differ by 1; CMP_LO reads 0xFFFFFFFF; `irq`=0.
- PRESCALE=3: `mtime` advances exactly once per 4 cycles over 40 cycles → increments by 10.
- Channel 0: CMP=100, ENABLE=1, one-shot → `irq` rises 2 edges after `mtime`=100. W1C STATUS → bit re-sets next cycle. Write CMP_HI=0xFFFFFFFF, then W1C → `irq` falls and stays 0.
- Channel 1: periodic, PERIOD=50, CMP=200 → STATUS pulses at `mtime` 200, 250, 300. With W1C after each pulse, three distinct `irq` assertions; CMP reads 350 afterwards.
- Simultaneous events:
  - W1C and match in the same cycle → `status` stays 1.
  - CMP write and periodic match in the same cycle → CMP holds the written value, no reload.
- Byte write 0xAB to MTIME_LO lane 2 only (strobe 4'b0100) → only bits [23:16] change, no increment that cycle. Reads in the window at offset 0xF0 → `read_hit`=1, `read_value`=0. Address BASE_ADDRESS+0x100 → `read_hit`=0.

Source files
------------

// File: rtl/mmio_timer_pkg.sv
// Register map constants and helpers shared by the mmio_timer block.
package mmio_timer_pkg;

  localparam logic [7:0] OFF_MTIME_LO = 8'h00;
  localparam logic [7:0] OFF_MTIME_HI = 8'h04;
  localparam logic [7:0] OFF_PRESCALE = 8'h08;
  localparam logic [7:0] OFF_STATUS   = 8'h0C;
  localparam logic [7:0] OFF_ENABLE   = 8'h10;
  localparam logic [7:0] CH_BASE      = 8'h20;
  localparam logic [7:0] CH_STRIDE    = 8'h10;

  localparam logic [3:0] OFF_CH_CMP_LO = 4'h0;
  localparam logic [3:0] OFF_CH_CMP_HI = 4'h4;
  localparam logic [3:0] OFF_CH_PERIOD = 4'h8;
  localparam logic [3:0] OFF_CH_CTRL   = 4'hC;

  localparam int unsigned CTRL_PERIODIC = 0;

  typedef enum logic [1:0] {
    CH_CMP_LO = 2'd0,
    CH_CMP_HI = 2'd1,
    CH_PERIOD = 2'd2,
    CH_CTRL   = 2'd3
  } ch_reg_e;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  strb);
    logic [31:0] m;
    m = old_word;
    for (int unsigned i = 0; i < 4; i++)
      if (strb[i]) m[8*i +: 8] = new_word[8*i +: 8];
    return m;
  endfunction

endpackage

// File: rtl/mmio_timer_channel.sv
// One compare channel: 64-bit cmp, match comparator and, with
// MMIO_TIMER_PERIODIC_EN defined, PERIOD/CTRL registers and the reload adder.
module mmio_timer_channel
  import mmio_timer_pkg::*;
(
  input  logic        clk24,
  input  logic        reset,
  input  logic [63:0] mtime,
  input  logic        write_en,
  input  ch_reg_e     sub,
  input  logic [31:0] write_value,
  input  logic [3:0]  write_sections,
  output logic        match,
  output logic [31:0] read_word
);

  logic [63:0] cmp;
  logic        wr_lo, wr_hi;

  assign match = mtime >= cmp;
  assign wr_lo = write_en && (sub == CH_CMP_LO);
  assign wr_hi = write_en && (sub == CH_CMP_HI);

`ifdef MMIO_TIMER_PERIODIC_EN
  logic [31:0] period;
  logic        periodic;
  logic        reload;

  assign reload = match && periodic && (period != '0);

  always_ff @(posedge clk24 or posedge reset) begin
    if (reset) begin
      period   <= '0;
      periodic <= 1'b0;
    end else begin
      if (write_en && (sub == CH_PERIOD))
        period <= merge_bytes(period, write_value, write_sections);
      if (write_en && (sub == CH_CTRL) && write_sections[0])
        periodic <= write_value[CTRL_PERIODIC];
    end
  end
`endif

  // A CPU write to either cmp half pre-empts that cycle's reload.
  always_ff @(posedge clk24 or posedge reset) begin
    if (reset)
      cmp <= '1;
    else if (wr_lo)
      cmp[31:0] <= merge_bytes(cmp[31:0], write_value, write_sections);
    else if (wr_hi)
      cmp[63:32] <= merge_bytes(cmp[63:32], write_value, write_sections);
`ifdef MMIO_TIMER_PERIODIC_EN
    else if (reload)
      cmp <= cmp + {32'd0, period};
`endif
  end

  always_comb begin
    read_word = '0;
    case (sub)
      CH_CMP_LO: read_word = cmp[31:0];
      CH_CMP_HI: read_word = cmp[63:32];
`ifdef MMIO_TIMER_PERIODIC_EN
      CH_PERIOD: read_word = period;
      CH_CTRL:   read_word = {31'd0, periodic};
`endif
      default:   read_word = '0;
    endcase
  end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped machine timer: prescaled 64-bit mtime plus NUM_CHANNELS compare
// channels. Define MMIO_TIMER_PERIODIC_EN to build PERIOD/CTRL and auto-reload.
module mmio_timer
  import mmio_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS   = 32'h8000_0000,
  parameter int unsigned NUM_CHANNELS   = 4,
  parameter int unsigned PRESCALE_WIDTH = 16
) (
  input  logic                    clk24,
  input  logic                    reset,
  input  logic [31:0]             address,
  input  logic [31:0]             write_value,
  input  logic [3:0]              write_sections,
  output logic [31:0]             read_value,
  output logic                    read_hit,
  output logic [NUM_CHANNELS-1:0] channel_irq,
  output logic                    irq
);

  localparam logic [3:0] NUM_CH4 = 4'(NUM_CHANNELS);

  logic [63:0]               mtime;
  logic [PRESCALE_WIDTH-1:0] presc_cnt;
  logic [PRESCALE_WIDTH-1:0] prescale;
  logic [NUM_CHANNELS-1:0]   status;
  logic [NUM_CHANNELS-1:0]   enable;
  logic [NUM_CHANNELS-1:0]   match_vec;
  logic [NUM_CHANNELS-1:0]   ch_sel;
  logic [NUM_CHANNELS-1:0]   status_clr;
  logic [31:0]               ch_read [NUM_CHANNELS];
  logic [31:0]               rd_word;
  logic [5:0]                word;
  logic [3:0]                ch_slot;
  logic                      in_window, do_write, ch_region, tick;
  logic                      wr_mtime_lo, wr_mtime_hi, wr_presc, wr_status, wr_enable;
  logic                      unused_addr_bits;

  assign unused_addr_bits = ^address[1:0];

  assign in_window = address[31:8] == BASE_ADDRESS[31:8];
  assign do_write  = in_window && (write_sections != '0);
  assign word      = address[7:2];
  assign ch_slot   = address[7:4] - 4'd2;
  assign ch_region = (address[7:4] >= 4'd2) && (ch_slot < NUM_CH4);

  assign wr_mtime_lo = do_write && (word == OFF_MTIME_LO[7:2]);
  assign wr_mtime_hi = do_write && (word == OFF_MTIME_HI[7:2]);
  assign wr_presc    = do_write && (word == OFF_PRESCALE[7:2]);
  assign wr_status   = do_write && (word == OFF_STATUS[7:2]);
  assign wr_enable   = do_write && (word == OFF_ENABLE[7:2]);

  assign tick = presc_cnt == prescale;

  for (genvar n = 0; n < NUM_CHANNELS; n++) begin : g_ch
    assign ch_sel[n] = in_window && ch_region && (ch_slot == 4'(n));

    mmio_timer_channel u_ch (
      .clk24          (clk24),
      .reset          (reset),
      .mtime          (mtime),
      .write_en       (ch_sel[n] && (write_sections != '0)),
      .sub            (ch_reg_e'(address[3:2])),
      .write_value    (write_value),
      .write_sections (write_sections),
      .match          (match_vec[n]),
      .read_word      (ch_read[n])
    );
  end

  // An mtime write freezes counting for that cycle and restarts the prescaler.
  always_ff @(posedge clk24 or posedge reset) begin
    if (reset) begin
      mtime     <= '0;
      presc_cnt <= '0;
      prescale  <= '0;
    end else begin
      if (wr_mtime_lo)
        mtime[31:0] <= merge_bytes(mtime[31:0], write_value, write_sections);
      else if (wr_mtime_hi)
        mtime[63:32] <= merge_bytes(mtime[63:32], write_value, write_sections);
      else if (tick)
        mtime <= mtime + 64'd1;

      if (wr_mtime_lo || wr_mtime_hi || wr_presc || tick)
        presc_cnt <= '0;
      else
        presc_cnt <= presc_cnt + 1'b1;

      if (wr_presc)
        prescale <= PRESCALE_WIDTH'(merge_bytes(32'(prescale), write_value, write_sections));
    end
  end

  assign status_clr = wr_status ? NUM_CHANNELS'(merge_bytes('0, write_value, write_sections))
                                : '0;

  // A match in the same cycle as a W1C keeps the bit set.
  always_ff @(posedge clk24 or posedge reset) begin
    if (reset) begin
      status <= '0;
      enable <= '0;
    end else begin
      status <= (status & ~status_clr) | match_vec;
      if (wr_enable)
        enable <= NUM_CHANNELS'(merge_bytes(32'(enable), write_value, write_sections));
    end
  end

  always_comb begin
    rd_word = '0;
    if (ch_region) begin
      for (int unsigned n = 0; n < NUM_CHANNELS; n++)
        if (ch_sel[n]) rd_word = ch_read[n];
    end else begin
      case (word)
        OFF_MTIME_LO[7:2]: rd_word = mtime[31:0];
        OFF_MTIME_HI[7:2]: rd_word = mtime[63:32];
        OFF_PRESCALE[7:2]: rd_word = 32'(prescale);
        OFF_STATUS[7:2]:   rd_word = 32'(status);
        OFF_ENABLE[7:2]:   rd_word = 32'(enable);
        default:           rd_word = '0;
      endcase
    end
  end

  always_ff @(posedge clk24 or posedge reset) begin
    if (reset) begin
      read_value  <= '0;
      read_hit    <= 1'b0;
      channel_irq <= '0;
      irq         <= 1'b0;
    end else begin
      read_hit    <= in_window;
      read_value  <= in_window ? rd_word : '0;
      channel_irq <= status & enable;
      irq         <= |(status & enable);
    end
  end

endmodule

// File: tb/tb_mmio_timer.sv
// Directed self-checking bench for mmio_timer; periodic checks follow MMIO_TIMER_PERIODIC_EN.
module tb_mmio_timer;

  localparam logic [31:0] BASE      = 32'h8000_0000;
  localparam logic [31:0] IDLE_ADDR = 32'h0000_0000;

  logic        clk24 = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] address = IDLE_ADDR;
  logic [31:0] write_value = '0;
  logic [3:0]  write_sections = '0;
  logic [31:0] read_value;
  logic        read_hit;
  logic [3:0]  channel_irq;
  logic        irq;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [31:0] rd, a, b;
  logic        hit;

  always #5 clk24 = ~clk24;

  mmio_timer #(
    .BASE_ADDRESS   (BASE),
    .NUM_CHANNELS   (4),
    .PRESCALE_WIDTH (16)
  ) dut (
    .clk24          (clk24),
    .reset          (reset),
    .address        (address),
    .write_value    (write_value),
    .write_sections (write_sections),
    .read_value     (read_value),
    .read_hit       (read_hit),
    .channel_irq    (channel_irq),
    .irq            (irq)
  );

  task automatic check_eq(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk24);
    #1;
  endtask

  task automatic bus_write(input logic [7:0] off, input logic [31:0] data, input logic [3:0] strb);
    address        = BASE + 32'(off);
    write_value    = data;
    write_sections = strb;
    @(posedge clk24);
    #1;
    address        = IDLE_ADDR;
    write_value    = '0;
    write_sections = '0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data, output logic h);
    address        = addr;
    write_sections = '0;
    @(posedge clk24);
    #1;
    data    = read_value;
    h       = read_hit;
    address = IDLE_ADDR;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    idle(3);
    check_eq("rst_read_value", read_value, 0);
    check_eq("rst_read_hit", read_hit, 0);
    check_eq("rst_irq", irq, 0);
    check_eq("rst_channel_irq", channel_irq, 0);
    reset = 1'b0;

    // Back-to-back mtime reads with PRESCALE=0
    bus_read(BASE + 32'h00, a, hit);
    bus_read(BASE + 32'h00, b, hit);
    check_eq("mtime_step", b - a, 1);
    check_eq("mtime_hit", hit, 1);
    bus_read(BASE + 32'h20, rd, hit);
    check_eq("cmp0_lo_reset", rd, 32'hFFFF_FFFF);
    check_eq("irq_idle", irq, 0);

    // Prescaler
    bus_write(8'h08, 32'hFFFF_FFFF, 4'hF);
    bus_read(BASE + 32'h08, rd, hit);
    check_eq("prescale_width", rd, 32'h0000_FFFF);
    bus_write(8'h08, 32'd3, 4'hF);
    bus_read(BASE + 32'h00, a, hit);
    idle(39);
    bus_read(BASE + 32'h00, b, hit);
    check_eq("prescale3_40cyc", b - a, 10);
    bus_write(8'h08, 32'd0, 4'hF);

    // Channel 0 one-shot
    bus_write(8'h00, 32'd0, 4'hF);
    bus_write(8'h24, 32'd0, 4'hF);
    bus_write(8'h20, 32'd100, 4'hF);
    bus_write(8'h10, 32'd1, 4'hF);
    bus_write(8'h00, 32'd90, 4'hF);
    idle(11);
    check_eq("ch0_irq_before", irq, 0);
    idle(1);
    check_eq("ch0_irq_rise", irq, 1);
    check_eq("ch0_channel_irq", channel_irq, 4'b0001);
    bus_read(BASE + 32'h0C, rd, hit);
    check_eq("ch0_status", rd, 1);
    bus_write(8'h0C, 32'd1, 4'hF);
    bus_read(BASE + 32'h0C, rd, hit);
    check_eq("w1c_vs_match", rd, 1);
    bus_write(8'h24, 32'hFFFF_FFFF, 4'hF);
    bus_write(8'h0C, 32'd1, 4'hF);
    check_eq("ch0_irq_hold", irq, 1);
    idle(1);
    check_eq("ch0_irq_fall", irq, 0);
    idle(5);
    check_eq("ch0_irq_stays_low", irq, 0);
    bus_read(BASE + 32'h0C, rd, hit);
    check_eq("ch0_status_clear", rd, 0);

    // Byte-lane write to MTIME_LO
    bus_write(8'h00, 32'h1234_5678, 4'hF);
    bus_write(8'h00, 32'hCDAB_EF01, 4'b0100);
    bus_read(BASE + 32'h00, rd, hit);
    check_eq("mtime_lane2", rd, 32'h12AB_5678);
    bus_read(BASE + 32'h04, rd, hit);
    check_eq("mtime_hi_zero", rd, 0);

    // Unmapped offset and out-of-window
    bus_read(BASE + 32'hF0, rd, hit);
    check_eq("unmapped_hit", hit, 1);
    check_eq("unmapped_value", rd, 0);
    bus_read(BASE + 32'h100, rd, hit);
    check_eq("outside_hit", hit, 0);

`ifdef MMIO_TIMER_PERIODIC_EN
    // Channel 1 periodic
    bus_write(8'h00, 32'd0, 4'hF);
    bus_write(8'h34, 32'd0, 4'hF);
    bus_write(8'h30, 32'd200, 4'hF);
    bus_write(8'h38, 32'd50, 4'hF);
    bus_write(8'h3C, 32'd1, 4'hF);
    bus_write(8'h10, 32'd2, 4'hF);
    bus_write(8'h00, 32'd190, 4'hF);
    idle(11);
    check_eq("p200_before", irq, 0);
    idle(1);
    check_eq("p200_irq", irq, 1);
    check_eq("p200_channel_irq", channel_irq, 4'b0010);
    bus_write(8'h0C, 32'd2, 4'hF);
    idle(1);
    check_eq("p200_cleared", irq, 0);
    idle(47);
    check_eq("p250_before", irq, 0);
    idle(1);
    check_eq("p250_irq", irq, 1);
    bus_write(8'h0C, 32'd2, 4'hF);
    idle(1);
    check_eq("p250_cleared", irq, 0);
    idle(47);
    check_eq("p300_before", irq, 0);
    idle(1);
    check_eq("p300_irq", irq, 1);
    bus_write(8'h0C, 32'd2, 4'hF);
    bus_read(BASE + 32'h30, rd, hit);
    check_eq("cmp1_after3", rd, 350);
    bus_read(BASE + 32'h34, rd, hit);
    check_eq("cmp1_hi_after3", rd, 0);

    // PERIOD=0 is one-shot, then CMP write beats a same-cycle reload
    bus_write(8'h38, 32'd0, 4'hF);
    bus_write(8'h30, 32'h10, 4'hF);
    idle(3);
    bus_read(BASE + 32'h30, rd, hit);
    check_eq("period0_oneshot", rd, 32'h10);
    bus_write(8'h38, 32'd50, 4'hF);
    bus_write(8'h30, 32'h20, 4'hF);
    bus_read(BASE + 32'h30, rd, hit);
    check_eq("cmp_write_priority", rd, 32'h20);
    bus_read(BASE + 32'h30, rd, hit);
    check_eq("catchup_reload", rd, 32'h52);
    bus_write(8'h3C, 32'd0, 4'hF);
`else
    bus_write(8'h38, 32'd50, 4'hF);
    bus_write(8'h3C, 32'd1, 4'hF);
    bus_read(BASE + 32'h38, rd, hit);
    check_eq("period_unmapped", rd, 0);
    bus_read(BASE + 32'h3C, rd, hit);
    check_eq("ctrl_unmapped", rd, 0);
    check_eq("ctrl_unmapped_hit", hit, 1);
`endif

    // Asynchronous reset mid-operation
    bus_write(8'h10, 32'd1, 4'hF);
    bus_write(8'h24, 32'd0, 4'hF);
    bus_write(8'h20, 32'd0, 4'hF);
    idle(3);
    check_eq("pre_reset_irq", irq, 1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("async_reset_irq", irq, 0);
    check_eq("async_reset_channel_irq", channel_irq, 0);
    @(posedge clk24);
    #1;
    reset = 1'b0;
    bus_read(BASE + 32'h20, rd, hit);
    check_eq("post_reset_cmp0", rd, 32'hFFFF_FFFF);
    bus_read(BASE + 32'h10, rd, hit);
    check_eq("post_reset_enable", rd, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
